// File: rtl/serial_io_controller_if.sv
// Bundle of memory-side and host-link signals for the serial I/O controller.
// The controller uses the slave modport. The master modport is for whatever drives it, such as data memory or a bench.
interface serial_io_controller_if #(
  parameter int DEPTH_LOG2 = 2
);
  logic [7:0]          mem_wdata_in;
  logic                mem_wren_in;
  logic                mem_rden_in;
  logic [7:0]          mem_rdata_out;
  logic                mem_valid_out;
  logic                mem_ready_out;
  logic [7:0]          tx_data_out;
  logic                tx_valid_out;
  logic                tx_ready_in;
  logic [7:0]          rx_data_in;
  logic                rx_valid_in;
  logic                rx_ready_out;
  logic                clear_flags_in;
  logic [DEPTH_LOG2:0] tx_count_out;
  logic [DEPTH_LOG2:0] rx_count_out;
  logic                tx_overrun_out;
  logic                rx_overrun_out;
  logic                rx_underrun_out;

  modport slave (
    input  mem_wdata_in, mem_wren_in, mem_rden_in, tx_ready_in,
           rx_data_in, rx_valid_in, clear_flags_in,
    output mem_rdata_out, mem_valid_out, mem_ready_out, tx_data_out,
           tx_valid_out, rx_ready_out, tx_count_out, rx_count_out,
           tx_overrun_out, rx_overrun_out, rx_underrun_out
  );

  modport master (
    output mem_wdata_in, mem_wren_in, mem_rden_in, tx_ready_in,
           rx_data_in, rx_valid_in, clear_flags_in,
    input  mem_rdata_out, mem_valid_out, mem_ready_out, tx_data_out,
           tx_valid_out, rx_ready_out, tx_count_out, rx_count_out,
           tx_overrun_out, rx_overrun_out, rx_underrun_out
  );
endinterface

// File: rtl/serial_io_controller.sv
// Byte buffering between the memory-stage serial port and a host byte link.
// It has a TX FIFO (CPU to host) and an RX FIFO (host to CPU), plus sticky overrun and underrun flags.

// Handshake rule used throughout: a transfer happens on a rising edge where valid && ready.
// ready and valid come only from registered counts, so a push into a full FIFO is refused even if a pop happens in the same cycle.
module sio_fifo #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [7:0]          push_data,
  input  logic                pop,
  output logic [7:0]          head,
  output logic                valid,
  output logic                ready,
  output logic [DEPTH_LOG2:0] count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            storage [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  push_ok;
  logic                  pop_ok;

  assign valid   = (cnt != '0);
  assign ready   = (cnt != FULL_COUNT);
  assign push_ok = push && ready;
  assign pop_ok  = pop && valid;
  assign count   = cnt;
  assign head    = valid ? storage[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      storage[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module serial_io_controller #(
  parameter int DEPTH_LOG2 = 2
) (
  input logic clk,
  input logic reset,
  serial_io_controller_if.slave bus
);
  logic tx_overrun_q;
  logic rx_overrun_q;
  logic rx_underrun_q;
  logic tx_overrun_set;
  logic rx_overrun_set;
  logic rx_underrun_set;

  sio_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.mem_wren_in),
    .push_data (bus.mem_wdata_in),
    .pop       (bus.tx_ready_in),
    .head      (bus.tx_data_out),
    .valid     (bus.tx_valid_out),
    .ready     (bus.mem_ready_out),
    .count     (bus.tx_count_out)
  );

  sio_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.rx_valid_in),
    .push_data (bus.rx_data_in),
    .pop       (bus.mem_rden_in),
    .head      (bus.mem_rdata_out),
    .valid     (bus.mem_valid_out),
    .ready     (bus.rx_ready_out),
    .count     (bus.rx_count_out)
  );

  assign tx_overrun_set  = bus.mem_wren_in && !bus.mem_ready_out;
  assign rx_overrun_set  = bus.rx_valid_in && !bus.rx_ready_out;
  assign rx_underrun_set = bus.mem_rden_in && !bus.mem_valid_out;

  // If a set event and a clear arrive in the same cycle, the set wins so the event is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_overrun_q  <= 1'b0;
      rx_overrun_q  <= 1'b0;
      rx_underrun_q <= 1'b0;
    end else begin
      if (tx_overrun_set)           tx_overrun_q  <= 1'b1;
      else if (bus.clear_flags_in)  tx_overrun_q  <= 1'b0;
      if (rx_overrun_set)           rx_overrun_q  <= 1'b1;
      else if (bus.clear_flags_in)  rx_overrun_q  <= 1'b0;
      if (rx_underrun_set)          rx_underrun_q <= 1'b1;
      else if (bus.clear_flags_in)  rx_underrun_q <= 1'b0;
    end
  end

  assign bus.tx_overrun_out  = tx_overrun_q;
  assign bus.rx_overrun_out  = rx_overrun_q;
  assign bus.rx_underrun_out = rx_underrun_q;
endmodule

// File: doc/serial_io_controller.md
Name: serial_io_controller

Overview:
- Buffers and sequences byte traffic between the data-memory serial port (memory stage) and an external UART/host byte link.
- Holds one TX FIFO (CPU to host) and one RX FIFO (host to CPU), each with valid/ready handshakes on the link side.
- Provides show-ahead read data to data memory, plus occupancy counts and sticky overrun/underrun flags for debug.
- Sits beside data_memory in the memory stage. It connects directly to data memory's serial_in/serial_valid_in/serial_ready_in/serial_out/serial_rden_out/serial_wren_out.

Parameters:
- DEPTH_LOG2, 2, log2 of entries per FIFO (default 4 entries each; legal range 1..6).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous active-high reset.
- mem_wdata_in, input, 8, byte written by data memory (its serial_out).
- mem_wren_in, input, 1, data memory write strobe (its serial_wren_out); one byte per cycle.
- mem_rden_in, input, 1, data memory read strobe (its serial_rden_out); pops the RX head.
- mem_rdata_out, output, 8, RX FIFO head byte, to data memory serial_in.
- mem_valid_out, output, 1, RX FIFO not empty, to serial_valid_in.
- mem_ready_out, output, 1, TX FIFO not full, to serial_ready_in.
- tx_data_out, output, 8, TX FIFO head byte to host link.
- tx_valid_out, output, 1, TX FIFO not empty.
- tx_ready_in, input, 1, host accepts tx_data_out this cycle.
- rx_data_in, input, 8, byte from host link.
- rx_valid_in, input, 1, rx_data_in valid.
- rx_ready_out, output, 1, RX FIFO not full.
- clear_flags_in, input, 1, clears the sticky flags.
- tx_count_out, output, DEPTH_LOG2+1, TX occupancy.
- rx_count_out, output, DEPTH_LOG2+1, RX occupancy.
- tx_overrun_out, output, 1, sticky: a memory write was dropped because TX was full.
- rx_overrun_out, output, 1, sticky: a host byte arrived while RX was full.
- rx_underrun_out, output, 1, sticky: mem_rden_in was asserted while RX was empty.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: both FIFOs empty; read/write pointers 0; counts 0.
  - mem_valid_out=0, tx_valid_out=0, mem_ready_out=1, rx_ready_out=1.
  - mem_rdata_out=8'h00, tx_data_out=8'h00.
  - All sticky flags 0.
- Reset mid-transfer discards all buffered bytes. Reset has priority over every other input in that cycle.
- All status outputs are derived from registered counts: valid = count!=0, ready = count!=DEPTH.
- Data outputs show the head entry when the FIFO is non-empty and 8'h00 when empty. They are combinational from registered storage and pointers.
- TX push: mem_wren_in && mem_ready_out writes mem_wdata_in at the write pointer.
  - The byte appears on tx_data_out/tx_valid_out in the next cycle (latency 1).
- TX pop: tx_valid_out && tx_ready_in advances the read pointer.
- RX push: rx_valid_in && rx_ready_out stores rx_data_in. It is visible on mem_valid_out/mem_rdata_out the next cycle.
- RX pop: mem_rden_in && mem_valid_out advances the RX read pointer.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. Counts are DEPTH_LOG2+1 bits.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, both pointers advance.
- Full FIFO with push and pop in the same cycle: the push is rejected because ready reflects the registered full state.
  - The pop proceeds and count becomes DEPTH-1.
  - For TX, the rejected push sets tx_overrun_out. For RX, it sets rx_overrun_out.
- Empty FIFO with push and pop in the same cycle: the pop is ignored, the push proceeds, and count becomes 1.
  - For RX, a pop while empty sets rx_underrun_out.
- Sticky flags: clear_flags_in clears them. If a set event occurs in the same cycle as clear_flags_in, the set wins and the flag stays 1.
- Dropped or ignored operations never change storage, pointers or counts.

Test Plan:
- Reset, then idle: mem_ready_out=1, rx_ready_out=1, all valids 0, all data outputs 8'h00, counts 0.
- Write 8'h48 then 8'h69 on consecutive cycles with tx_ready_in=0.
  - Expect tx_valid_out=1 from the cycle after the first write, tx_data_out=8'h48, tx_count_out=2.
  - Raise tx_ready_in for 2 cycles: expect 8'h48 then 8'h69 out, then tx_valid_out=0.
- Fill TX with 4 bytes (DEPTH_LOG2=2) and write a 5th byte while popping in the same cycle.
  - Expect the 5th byte dropped, tx_count_out=3, tx_overrun_out=1.
  - Pulse clear_flags_in and expect the flag to return to 0.
- Push host bytes 8'hA0..8'hA5 with rx_valid_in held, 6 cycles, mem_rden_in=0.
  - Expect rx_ready_out=0 after 4 bytes and rx_overrun_out=1.
  - Pop 4 times: expect A0, A1, A2, A3, then mem_valid_out=0.
- With RX empty, assert mem_rden_in: expect rx_underrun_out=1 and rx_count_out=0.
  - Then push 8'h55 and pop in the same cycle: expect count 1 and mem_rdata_out=8'h55.
- Wrap-around: stream 10 bytes through TX with concurrent push/pop. Expect in-order output and count never above 4.
  - Assert reset mid-stream: expect everything empty the next cycle.
